// File: rtl/shiftadd_mult.sv
// rtl/shiftadd_mult.sv - radix-2 shift-and-add multiplier, product = a*b (+c with ADDEND_EN)
// Optional addend feature selected by `define ADDEND_EN.
module shiftadd_mult #(
    parameter int WIDTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] acc_init;

`ifdef ADDEND_EN
    assign acc_init = {{WIDTH{1'b0}}, c};
`else
    // c is kept on the port for a uniform interface; it drives nothing.
    logic unused_c;
    assign unused_c = ^c;
    assign acc_init = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    acc_d   = acc_init;
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mult_d  = b;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = acc_q;
                end else begin
                    if (mult_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    mult_d  = mult_q >> 1;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // Accepting on the DONE exit edge gives a WIDTH+2 issue interval.
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CW'(WIDTH);
                    acc_d   = acc_init;
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mult_d  = b;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shiftadd_mult.sv
// tb/tb_shiftadd_mult.sv - randomized self-checking bench for shiftadd_mult (WIDTH=8)
module tb_shiftadd_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b, c;
    logic           busy, done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shiftadd_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, mb, mc);
        longint unsigned p;
        p = longint'(ma) * longint'(mb);
`ifdef ADDEND_EN
        p = p + longint'(mc);
`endif
        return p[2*W-1:0];
    endfunction

    // One transaction; with noisy set, start and operands toggle while busy.
    task automatic run_op(input logic [W-1:0] ta, tb_, tc, input bit noisy);
        logic [2*W-1:0] exp;
        int k;
        bit seen;
        exp = model(ta, tb_, tc);
        @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        if (noisy) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom); start = 1'b1;
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < W + 10) begin
            @(posedge clk); #1;
            k++;
            if (k == 3) start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) break;
        end
        check("done_latency", k, W + 1);
        check("busy_at_done", busy, 1);
        check("product", product, exp);
        @(posedge clk); #1;
        check("done_pulse_end", done, 0);
        check("busy_end", busy, 0);
        check("product_held", product, exp);
    endtask

    initial begin
        int t1, t2, nd;
        logic [W-1:0] ra, rb, rc;
        logic [2*W-1:0] e1;

        rst = 1'b1; start = 1'b1; a = '1; b = '1; c = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        run_op(8'd13, 8'd11, 8'd0, 1'b0);
        run_op(8'd255, 8'd255, 8'd255, 1'b1);
        run_op(8'd0, 8'd200, 8'd7, 1'b0);
        run_op(8'd200, 8'd0, 8'd9, 1'b1);

        // start held high: back-to-back results
        e1 = model(8'd77, 8'd99, 8'd5);
        @(negedge clk);
        a = 8'd77; b = 8'd99; c = 8'd5; start = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 4 * W + 20 && t2 < 0; i++) begin
            @(posedge clk); #1;
            if (done) begin
                check("b2b_product", product, e1);
                if (t1 < 0) t1 = cyc;
                else begin
                    t2 = cyc;
                    start = 1'b0;
                end
            end
        end
        check("b2b_interval", t2 - t1, W + 2);
        @(posedge clk); #1;
        check("b2b_idle", busy, 0);

        // reset three cycles into BUSY
        @(negedge clk);
        a = 8'd21; b = 8'd34; c = 8'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        nd = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midrst_no_done", nd, 0);
        run_op(8'd3, 8'd5, 8'd0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
            run_op(ra, rb, rc, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
